// File: rtl/mem_stage_lsu.sv
// MEM stage: load/store unit with req/ready data-memory handshake,
// request timeout, misalignment detection and the MEM/WB register.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_output,
  input  logic [31:0] mem_rdata2,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm,
  input  logic [2:0]  mem_funct3,
  input  logic        mem_regwrite,
  input  logic        mem_memwrite,
  input  logic [1:0]  mem_memtoreg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu_output,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm,
  output logic [31:0] wb_load_data,
  output logic        wb_regwrite,
  output logic [1:0]  wb_memtoreg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last counter value before the access is abandoned.
  localparam logic [7:0] TO_LAST =
    (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;

  logic        is_load;
  logic        access;
  logic        misal;
  logic        go;
  logic        wb_en;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  // Access classification and stall request.
  always_comb begin
    is_load = (mem_memtoreg == 2'b01);
    access  = is_load | mem_memwrite;
    misal   = 1'b0;
    unique case (1'b1)
      (mem_funct3[1:0] == 2'b01):
        misal = mem_alu_output[0];
      (mem_funct3[1:0] == 2'b10):
        misal = (mem_alu_output[1:0] != 2'b00);
      default:
        misal = 1'b0;
    endcase
    go      = (state == IDLE) & access & ~misal;
    stall_o = rst_n & (go | (state == REQ));
    wb_en   = mem_regwrite & ~stall_o
            & ~((state == IDLE) & access & misal)
            & ~((state == RESP) & bus_err_o);
  end

  // Store lane steering and byte enables.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = mem_rdata2;
    unique case (mem_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << mem_alu_output[1:0];
        wdata_n = {4{mem_rdata2[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << mem_alu_output[1:0];
        wdata_n = {2{mem_rdata2[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = mem_rdata2;
      end
    endcase
    if (is_load)
      be_n = 4'b1111;
  end

  // Load byte/half selection and extension.
  always_comb begin
    ld_b = rdata_q[7:0];
    unique case (mem_alu_output[1:0])
      2'b00: ld_b = rdata_q[7:0];
      2'b01: ld_b = rdata_q[15:8];
      2'b10: ld_b = rdata_q[23:16];
      2'b11: ld_b = rdata_q[31:24];
    endcase
    ld_h = mem_alu_output[1] ?
      rdata_q[31:16] : rdata_q[15:0];
    unique case (mem_funct3)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'd0, ld_b};
      3'b101:  ld_ext = {16'd0, ld_h};
      default: ld_ext = rdata_q;
    endcase
  end

  // Access FSM with registered memory interface and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata_q    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state      <= REQ;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_memwrite & ~is_load;
            dmem_addr  <= {mem_alu_output[31:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_be    <= be_n;
          end else if (access && misal) begin
            misalign_o <= 1'b1;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= RESP;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            rdata_q   <= '0;
            dmem_req  <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register; stalled edges insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd         <= '0;
      wb_alu_output <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm        <= '0;
      wb_load_data  <= '0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= '0;
    end else begin
      wb_rd         <= mem_rd;
      wb_alu_output <= mem_alu_output;
      wb_pc_plus_4  <= mem_pc_plus_4;
      wb_imm        <= mem_imm;
      wb_load_data  <= ld_ext;
      wb_regwrite   <= wb_en;
      wb_memtoreg   <= mem_memtoreg;
    end
  end

endmodule
